// File: rtl/wrapper_register_file.sv
// -----------------------------------------------------------------------------
// wrapper_register_file
//
// General-purpose register file for a MIPS-style datapath, exposed under the
// datapath's field names. Holds 2**BITS registers of WIDTH bits with one
// synchronous write port and two combinational read ports. Register 0 is
// hardwired to zero.
//
// Ports:
//   clock        in   1      system clock, all state updates on rising edge
//   reset        in   1      synchronous active-high reset, clears every register
//   rs           in   BITS   write register address
//   rt           in   BITS   read port 1 address
//   rd           in   BITS   read port 2 address
//   R_rd         in   WIDTH  write data
//   Reg_Write_i  in   1      write enable, active high
//   R_rs         out  WIDTH  read port 1 data (contents of register rt)
//   R_rt         out  WIDTH  read port 2 data (contents of register rd)
// -----------------------------------------------------------------------------
module wrapper_register_file #(
   parameter int WIDTH = 32,
   parameter int BITS  = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [BITS-1:0]  rs,
   input  logic [BITS-1:0]  rt,
   input  logic [BITS-1:0]  rd,
   input  logic [WIDTH-1:0] R_rd,
   input  logic             Reg_Write_i,
   output logic [WIDTH-1:0] R_rs,
   output logic [WIDTH-1:0] R_rt
);

   localparam int DEPTH = 2 ** BITS;

   logic [WIDTH-1:0] regs [0:DEPTH-1];
   logic [DEPTH-1:0] wr_sel;

   // One-hot write decoder. Entry 0 is never selected, which is what makes
   // register 0 ignore writes.
   always_comb begin
      wr_sel = '0;
      if (Reg_Write_i) begin
         wr_sel[rs] = 1'b1;
      end
      wr_sel[0] = 1'b0;
   end

   // Register array. Reset takes priority over a simultaneous write.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            regs[i] <= '0;
         end else if (wr_sel[i]) begin
            regs[i] <= R_rd;
         end
      end
   end

   // Combinational read muxes with no write bypass. Address 0 is masked to
   // zero so it reads 0 even before the first reset has initialised storage.
   assign R_rs = (rt == '0) ? '0 : regs[rt];
   assign R_rt = (rd == '0) ? '0 : regs[rd];

endmodule

// File: tb/tb_wrapper_register_file.sv
// -----------------------------------------------------------------------------
// tb_wrapper_register_file
//
// Directed self-checking bench for wrapper_register_file (WIDTH=32, BITS=5).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_wrapper_register_file;

   logic        clock;
   logic        reset;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] R_rd;
   logic        Reg_Write_i;
   logic [31:0] R_rs;
   logic [31:0] R_rt;

   int tests  = 0;
   int failed = 0;

   wrapper_register_file #(
      .WIDTH(32),
      .BITS (5)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .R_rd        (R_rd),
      .Reg_Write_i (Reg_Write_i),
      .R_rs        (R_rs),
      .R_rt        (R_rt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rs = a; R_rd = d; Reg_Write_i = 1'b1;
      tick();
      Reg_Write_i = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rs = '0; rt = '0; rd = '0; R_rd = '0; Reg_Write_i = 1'b0;

      // Register 0 reads zero before any reset edge.
      #1;
      check("r0_pre_reset_rs", R_rs, 32'h0);
      check("r0_pre_reset_rt", R_rt, 32'h0);

      tick();
      reset = 1'b0;
      rt = 5'd13; rd = 5'd31;
      #1;
      check("reset_state_r13", R_rs, 32'h0);
      check("reset_state_r31", R_rt, 32'h0);

      // Reset clears a previously written register.
      wr(5'd5, 32'h12345678);
      rt = 5'd5; rd = 5'd5;
      #1;
      check("r5_written", R_rs, 32'h12345678);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("reset_clear_rs", R_rs, 32'h0);
      check("reset_clear_rt", R_rt, 32'h0);

      // Basic writes on successive edges, then read back on both ports.
      wr(5'd2,  32'd7);
      wr(5'd4,  32'd20);
      wr(5'd25, 32'd6);
      wr(5'd31, 32'd78);
      rt = 5'd2;  rd = 5'd2;  #1;
      check("rd_r2_rs", R_rs, 32'd7);   check("rd_r2_rt", R_rt, 32'd7);
      rt = 5'd4;  rd = 5'd4;  #1;
      check("rd_r4_rs", R_rs, 32'd20);  check("rd_r4_rt", R_rt, 32'd20);
      rt = 5'd25; rd = 5'd25; #1;
      check("rd_r25_rs", R_rs, 32'd6);  check("rd_r25_rt", R_rt, 32'd6);
      rt = 5'd31; rd = 5'd31; #1;
      check("rd_r31_rs", R_rs, 32'd78); check("rd_r31_rt", R_rt, 32'd78);

      // Writes to register 0 are ignored.
      wr(5'd0, 32'd3);
      rt = 5'd0; rd = 5'd0; #1;
      check("r0_write_rs", R_rs, 32'h0);
      check("r0_write_rt", R_rt, 32'h0);

      // Write enable low leaves the array unchanged.
      rs = 5'd7; R_rd = 32'hDEADBEEF; Reg_Write_i = 1'b0;
      tick();
      rd = 5'd7; #1;
      check("we_low_r7", R_rt, 32'h0);

      // No bypass: old value before the edge, new value after it.
      rs = 5'd9; rt = 5'd9; R_rd = 32'hAA; Reg_Write_i = 1'b1;
      #1;
      check("no_bypass_before", R_rs, 32'h0);
      tick();
      check("no_bypass_after", R_rs, 32'hAA);

      // Reset wins over a simultaneous write.
      reset = 1'b1; R_rd = 32'h55;
      tick();
      check("reset_priority_r9", R_rs, 32'h0);
      tick();
      check("reset_held_r9", R_rs, 32'h0);
      reset = 1'b0; Reg_Write_i = 1'b0;
      rt = 5'd31; #1;
      check("reset_cleared_r31", R_rs, 32'h0);

      // Dual-port independence and same-cycle address swap.
      wr(5'd3, 32'h11);
      wr(5'd6, 32'h22);
      rt = 5'd3; rd = 5'd6; #1;
      check("dual_rs_r3", R_rs, 32'h11);
      check("dual_rt_r6", R_rt, 32'h22);
      rt = 5'd6; rd = 5'd3; #1;
      check("swap_rs_r6", R_rs, 32'h22);
      check("swap_rt_r3", R_rt, 32'h11);

      // Overwrite keeps other registers intact.
      wr(5'd3, 32'hFFFF_FFFF);
      #1;
      check("overwrite_r3", R_rt, 32'hFFFF_FFFF);
      check("untouched_r6", R_rs, 32'h22);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
